// File: rtl/snes_joy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snes_joy_pkg
// Brief    : Shared constants for the SNES controller reader: raw bit order,
//            gb joystick bit positions, FSM encoding and the button mapping.
// Revision : 1.0
// ============================================================================
package snes_joy_pkg;

    localparam int SNES_B       = 0;
    localparam int SNES_Y       = 1;
    localparam int SNES_SELECT  = 2;
    localparam int SNES_START   = 3;
    localparam int SNES_UP      = 4;
    localparam int SNES_DOWN    = 5;
    localparam int SNES_LEFT    = 6;
    localparam int SNES_RIGHT   = 7;
    localparam int SNES_A       = 8;
    localparam int SNES_X       = 9;
    localparam int SNES_L       = 10;
    localparam int SNES_R       = 11;
    localparam int SNES_SIG_LSB = 12;

    localparam int JOY_RIGHT  = 0;
    localparam int JOY_LEFT   = 1;
    localparam int JOY_UP     = 2;
    localparam int JOY_DOWN   = 3;
    localparam int JOY_A      = 4;
    localparam int JOY_B      = 5;
    localparam int JOY_SELECT = 6;
    localparam int JOY_START  = 7;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_STROBE = 3'd1;
    localparam logic [2:0] ST_HIGH   = 3'd2;
    localparam logic [2:0] ST_LOW    = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Pressed-high SNES buttons to the gb joystick byte.
    function automatic logic [7:0] snes_to_joy(input logic [11:0] p);
        logic [7:0] j;
        j             = '0;
        j[JOY_RIGHT]  = p[SNES_RIGHT];
        j[JOY_LEFT]   = p[SNES_LEFT];
        j[JOY_UP]     = p[SNES_UP];
        j[JOY_DOWN]   = p[SNES_DOWN];
        j[JOY_A]      = p[SNES_A];
        j[JOY_B]      = p[SNES_B];
        j[JOY_SELECT] = p[SNES_SELECT];
        j[JOY_START]  = p[SNES_START];
        return j;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snes_joy_sync.sv
`default_nettype none
// ============================================================================
// Module   : snes_joy_sync
// Brief    : Two-flop synchroniser for the controller data line (idles high).
// Revision : 1.0
// ============================================================================
module snes_joy_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/snes_joy_reader.sv
`default_nettype none
// ============================================================================
// Module   : snes_joy_reader
// Brief    : Polls a SNES controller (strobe + 16 clocked bits) and produces the
//            gb joystick byte. Define SNES_JOY_TURBO_EN to add X/Y turbo.
// Revision : 1.0
// ============================================================================
module snes_joy_reader
    import snes_joy_pkg::*;
#(
    parameter int STROBE_CYCLES = 50,
    parameter int HALF_CYCLES   = 25,
    parameter int POLL_CYCLES   = 69905,
    parameter int TURBO_FRAMES  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        joy_data,
    output logic        joy_strobe,
    output logic        joy_clock,
    output logic [7:0]  joystick,
    output logic [11:0] buttons,
    output logic        connected,
    output logic        frame_done
);

    localparam int c_CNT_MAX = (STROBE_CYCLES > HALF_CYCLES) ? STROBE_CYCLES : HALF_CYCLES;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam int c_POLL_W  = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

    if (HALF_CYCLES < 4 || STROBE_CYCLES < 1 || TURBO_FRAMES < 1) begin : g_param_check
        $error("snes_joy_reader: illegal timing parameters");
    end

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_POLL_W-1:0] r_poll;
    logic [3:0]          r_bit;
    logic [14:0]         r_raw;
    logic                r_strobe;
    logic                r_jclk;
    logic [7:0]          r_joy;
    logic [11:0]         r_buttons;
    logic                r_connected;
    logic                r_frame_done;

    logic                w_data_s;
    logic                w_last;
    logic [15:0]         w_raw_full;
    logic [11:0]         w_p;
    logic                w_sig_ok;
    logic [7:0]          w_joy_base;
    logic [7:0]          w_joy;

    snes_joy_sync u_sync (
        .clk (clk),
        .rst (reset),
        .i_d (joy_data),
        .o_q (w_data_s)
    );

    assign w_last = (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (r_poll == '0) w_state_nxt = ST_STROBE;
            ST_STROBE: if (w_last) w_state_nxt = ST_HIGH;
            ST_HIGH:   if (w_last) w_state_nxt = (r_bit == 4'd15) ? ST_DONE : ST_LOW;
            ST_LOW:    if (w_last) w_state_nxt = ST_HIGH;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Bit 15 is still on the synchroniser output when DONE is entered.
    assign w_raw_full = {w_data_s, r_raw};
    assign w_p        = ~w_raw_full[11:0];
    assign w_sig_ok   = (w_raw_full[15:SNES_SIG_LSB] == 4'hF);
    assign w_joy_base = snes_to_joy(w_p);

`ifdef SNES_JOY_TURBO_EN
    localparam int c_TF_W = (TURBO_FRAMES > 1) ? $clog2(TURBO_FRAMES) : 1;

    logic              r_phase;
    logic [c_TF_W-1:0] r_tcnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= 1'b0;
            r_tcnt  <= '0;
        end else if (w_state_nxt == ST_DONE && w_sig_ok) begin
            if (r_tcnt == c_TF_W'(TURBO_FRAMES - 1)) begin
                r_tcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_tcnt <= r_tcnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_joy        = w_joy_base;
        w_joy[JOY_A] = w_p[SNES_A] | (w_p[SNES_X] & r_phase);
        w_joy[JOY_B] = w_p[SNES_B] | (w_p[SNES_Y] & r_phase);
    end
`else
    always_comb begin
        w_joy = w_joy_base;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_poll       <= '0;
            r_bit        <= 4'd0;
            r_raw        <= '1;
            r_strobe     <= 1'b0;
            r_jclk       <= 1'b1;
            r_joy        <= 8'h00;
            r_buttons    <= 12'h000;
            r_connected  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_strobe     <= (w_state_nxt == ST_STROBE);
            r_jclk       <= (w_state_nxt != ST_LOW);
            r_frame_done <= (w_state_nxt == ST_DONE);

            if (r_state == ST_IDLE && w_state_nxt == ST_STROBE) begin
                r_poll <= c_POLL_W'(POLL_CYCLES - 1);
            end else if (r_poll != '0) begin
                r_poll <= r_poll - 1'b1;
            end

            if (w_state_nxt != r_state) begin
                case (w_state_nxt)
                    ST_STROBE: r_cnt <= c_CNT_W'(STROBE_CYCLES - 1);
                    ST_HIGH:   r_cnt <= c_CNT_W'(HALF_CYCLES - 1);
                    ST_LOW:    r_cnt <= c_CNT_W'(HALF_CYCLES - 1);
                    default:   r_cnt <= '0;
                endcase
            end else if (!w_last) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_state_nxt == ST_STROBE) begin
                r_bit <= 4'd0;
            end else if (r_state == ST_HIGH && w_last && r_bit != 4'd15) begin
                r_bit <= r_bit + 4'd1;
                r_raw <= {w_data_s, r_raw[14:1]};
            end

            if (w_state_nxt == ST_DONE) begin
                r_connected <= w_sig_ok;
                r_buttons   <= w_sig_ok ? w_p   : 12'h000;
                r_joy       <= w_sig_ok ? w_joy : 8'h00;
            end
        end
    end

    assign joy_strobe = r_strobe;
    assign joy_clock  = r_jclk;
    assign joystick   = r_joy;
    assign buttons    = r_buttons;
    assign connected  = r_connected;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_snes_joy_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_snes_joy_reader
// Brief    : Directed bench for snes_joy_reader with a behavioural controller.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_snes_joy_reader;

    localparam int c_POLL = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        joy_data;
    logic        joy_strobe;
    logic        joy_clock;
    logic [7:0]  joystick;
    logic [11:0] buttons;
    logic        connected;
    logic        frame_done;

    logic [15:0] m_raw  = 16'hFFFF;
    logic [15:0] m_sh   = 16'hFFFF;
    logic        m_tie0 = 1'b0;
    logic        m_prev = 1'b1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    snes_joy_reader #(
        .STROBE_CYCLES (50),
        .HALF_CYCLES   (25),
        .POLL_CYCLES   (c_POLL),
        .TURBO_FRAMES  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .joy_data   (joy_data),
        .joy_strobe (joy_strobe),
        .joy_clock  (joy_clock),
        .joystick   (joystick),
        .buttons    (buttons),
        .connected  (connected),
        .frame_done (frame_done)
    );

    // Controller: parallel load while strobed, shift on each rising joy_clock.
    always @(posedge clk) begin
        m_prev <= joy_clock;
        if (joy_strobe)
            m_sh <= m_raw;
        else if (joy_clock && !m_prev)
            m_sh <= {1'b1, m_sh[15:1]};
    end

    assign joy_data = m_tie0 ? 1'b0 : m_sh[0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(output int edges, output int s_c, output int lo_c,
                              output int lo_p, output bit first_s, output bit ok);
        bit prev;
        edges = 0; s_c = 0; lo_c = 0; lo_p = 0; first_s = 0; ok = 0;
        prev = joy_clock;
        while (!ok && edges < 2500) begin
            tick();
            edges++;
            if (edges == 1) first_s = joy_strobe;
            if (joy_strobe) s_c++;
            if (!joy_clock) lo_c++;
            if (prev && !joy_clock) lo_p++;
            prev = joy_clock;
            if (frame_done) ok = 1;
        end
    endtask

    int edges, s_c, lo_c, lo_p;
    bit first_s, ok;
    bit exp_a;

    initial begin
        reset = 1'b1;
        repeat (4) tick();
        chk("rst_strobe", joy_strobe, 0);
        chk("rst_jclk", joy_clock, 1);
        chk("rst_joy", joystick, 8'h00);
        chk("rst_btn", buttons, 12'h000);
        chk("rst_conn", connected, 0);
        chk("rst_done", frame_done, 0);

        reset = 1'b0;
        wait_frame(edges, s_c, lo_c, lo_p, first_s, ok);
        chk("f1_ok", ok, 1);
        chk("f1_first_strobe", first_s, 1);
        chk("f1_len", edges, 826);
        chk("f1_strobe_cyc", s_c, 50);
        chk("f1_low_cyc", lo_c, 375);
        chk("f1_low_pulses", lo_p, 15);
        chk("f1_joy", joystick, 8'h00);
        chk("f1_btn", buttons, 12'h000);
        chk("f1_conn", connected, 1);

        m_raw = ~16'h0108;
        wait_frame(edges, s_c, lo_c, lo_p, first_s, ok);
        chk("f2_period", edges, c_POLL);
        chk("f2_joy", joystick, 8'h90);
        chk("f2_btn", buttons, 12'h108);
        chk("f2_conn", connected, 1);

        m_raw = ~16'h0051;
        wait_frame(edges, s_c, lo_c, lo_p, first_s, ok);
        chk("f3_joy", joystick, 8'h26);
        chk("f3_btn", buttons, 12'h051);

        m_raw = ~16'h00F0;
        wait_frame(edges, s_c, lo_c, lo_p, first_s, ok);
        chk("f4_opposing_joy", joystick, 8'h0F);
        chk("f4_opposing_btn", buttons, 12'h0F0);

        m_tie0 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_frame(edges, s_c, lo_c, lo_p, first_s, ok);
            chk("tie0_period", edges, c_POLL);
            chk("tie0_conn", connected, 0);
            chk("tie0_joy", joystick, 8'h00);
            chk("tie0_btn", buttons, 12'h000);
        end

        m_tie0 = 1'b0;
        m_raw  = ~16'h0108;
        wait_frame(edges, s_c, lo_c, lo_p, first_s, ok);
        chk("f7_joy", joystick, 8'h90);

        // Abort inside the 16th half-period (a low phase).
        edges = 0;
        while (!joy_strobe && edges < 2500) begin
            tick();
            edges++;
        end
        chk("mid_strobe_seen", joy_strobe, 1);
        repeat (430) tick();
        chk("mid_jclk_low", joy_clock, 0);
        reset  = 1'b1;
        m_raw  = ~16'h0200;
        tick();
        chk("mid_rst_jclk", joy_clock, 1);
        chk("mid_rst_strobe", joy_strobe, 0);
        chk("mid_rst_joy", joystick, 8'h00);
        chk("mid_rst_conn", connected, 0);
        reset = 1'b0;

        for (int k = 0; k < 8; k++) begin
            wait_frame(edges, s_c, lo_c, lo_p, first_s, ok);
            if (k == 0) begin
                chk("post_rst_len", edges, 826);
                chk("post_rst_btn", buttons, 12'h200);
            end
`ifdef SNES_JOY_TURBO_EN
            exp_a = ((k / 4) % 2) == 1;
`else
            exp_a = 1'b0;
`endif
            chk("turbo_a", joystick[4], exp_a);
            chk("turbo_rest", joystick & 8'hEF, 8'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
